// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
// Shared CPU definitions: datapath width, the NOP encoding, the PC step and
// the entry type stored in the fetch prefetch FIFO.
// No ports (package).
// ----------------------------------------------------------------------------
package cpu_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_INC    = 32'd4;

    // One fetched instruction together with the PC+4 of the fetch address
    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc_plus_4;
    } fetch_entry_t;

    // Clears the two byte-offset bits so every fetch address is word aligned
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// ----------------------------------------------------------------------------
// fetch_fifo
// Small prefetch FIFO holding fetch_entry_t records between instruction memory
// and the IF/ID register. The head is presented combinationally; an empty
// FIFO presents a NOP with a zero PC+4.
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset (empties the FIFO)
//   push       in   write push_data at the tail
//   push_data  in   entry to write
//   pop        in   drop the head entry (ignored when empty)
//   flush      in   discard every entry; wins over push and pop
//   count      out  number of valid entries (0..DEPTH)
//   empty      out  no valid entries
//   head       out  head entry, or NOP/0 when empty
// ----------------------------------------------------------------------------
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  fetch_entry_t         push_data,
    input  logic                 pop,
    input  logic                 flush,
    output logic [$clog2(DEPTH):0] count,
    output logic                 empty,
    output fetch_entry_t         head
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    fetch_entry_t     storage [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit: equal pointers mean empty, equal
    // index with differing wrap bits means full.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[IDX_W] != rd_ptr[IDX_W]) &&
                   (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
    assign count = wr_ptr - rd_ptr;

    // A push into a full FIFO is only taken when the head leaves in the
    // same cycle, so the storage can never be overrun.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // Storage needs no reset: entries are only observed while counted valid.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            storage[wr_ptr[IDX_W-1:0]] <= push_data;
        end
    end

    always_comb begin
        head = '{instr: NOP_INSTR, pc_plus_4: '0};
        if (!empty) begin
            head = storage[rd_ptr[IDX_W-1:0]];
        end
    end

endmodule

// File: rtl/fetch_prefetch_stage.sv
// ----------------------------------------------------------------------------
// fetch_prefetch_stage
// Instruction-fetch stage feeding the IF/ID register. Owns the PC, issues at
// most one outstanding request to a variable-latency instruction memory and
// buffers returned {instr, pc+4} pairs in a prefetch FIFO so ID stalls do not
// block memory. A MEM-stage redirect flushes the FIFO and drops the response
// of any request still in flight.
// Ports:
//   clk              in   rising-edge clock
//   startin          in   asynchronous active-low reset
//   imem_req         out  one-cycle fetch request (always accepted)
//   imem_addr        out  word-aligned fetch address, valid with imem_req
//   imem_ack         in   read data valid, >=1 cycle after imem_req
//   imem_rdata       in   instruction word, valid with imem_ack
//   redirect_valid   in   taken branch from MEM
//   redirect_target  in   branch target (low two bits ignored)
//   id_ready         in   IF/ID register accepts the head this cycle
//   if_valid         out  IF_instr / IF_pc_plus_4 hold a real instruction
//   IF_instr         out  FIFO head instruction, NOP when empty
//   IF_pc_plus_4     out  FIFO head fetch PC + 4, zero when empty
// ----------------------------------------------------------------------------
module fetch_prefetch_stage
    import cpu_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        startin,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        id_ready,
    output logic        if_valid,
    output logic [31:0] IF_instr,
    output logic [31:0] IF_pc_plus_4
);

    localparam int              CNT_W     = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    logic [XLEN-1:0]  fetch_pc;
    logic [XLEN-1:0]  req_addr;
    logic             outstanding;
    logic             discard;
    logic             issue;
    logic             accept;
    logic             pop;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_empty;
    fetch_entry_t     push_entry;
    fetch_entry_t     head;

    // The FIFO count has no in-flight slot reserved: with a single request
    // outstanding, a free slot at issue time is still free when it returns.
    // Gating with startin keeps the request low while reset is held.
    assign issue = startin && !outstanding && !discard && !redirect_valid &&
                   (fifo_count < DEPTH_CNT);

    // Responses are only taken for a live request that is not being
    // squashed, either by an earlier redirect or one arriving right now.
    assign accept = imem_ack && outstanding && !discard && !redirect_valid;

    assign push_entry = '{instr: imem_rdata, pc_plus_4: req_addr + PC_INC};

    assign imem_req  = issue;
    assign imem_addr = fetch_pc;

    assign if_valid     = !fifo_empty;
    assign IF_instr     = head.instr;
    assign IF_pc_plus_4 = head.pc_plus_4;
    assign pop          = if_valid && id_ready;

    // PC and request tracking. A redirect restarts the PC at the target; if
    // the in-flight request is not acknowledged in that same cycle, its
    // eventual ack must be swallowed, which is what discard records. Further
    // redirects while discarding simply move the PC again.
    always_ff @(posedge clk or negedge startin) begin
        if (!startin) begin
            fetch_pc    <= RESET_PC;
            req_addr    <= '0;
            outstanding <= 1'b0;
            discard     <= 1'b0;
        end else if (redirect_valid) begin
            fetch_pc    <= word_align(redirect_target);
            outstanding <= outstanding && !imem_ack;
            discard     <= outstanding && !imem_ack;
        end else if (issue) begin
            outstanding <= 1'b1;
            req_addr    <= fetch_pc;
            fetch_pc    <= fetch_pc + PC_INC;
        end else if (outstanding && imem_ack) begin
            outstanding <= 1'b0;
            discard     <= 1'b0;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (startin),
        .push      (accept),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (redirect_valid),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .head      (head)
    );

endmodule

// File: tb/tb_fetch_prefetch_stage.sv
// ----------------------------------------------------------------------------
// tb_fetch_prefetch_stage
// Bench for fetch_prefetch_stage: an instruction memory with programmable
// latency, a stream-level reference of what ID should see, a directed table,
// hand-written redirect/reset sequences and a randomized run.
// ----------------------------------------------------------------------------
module tb_fetch_prefetch_stage;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        startin = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic        id_ready = 1'b0;
    logic        if_valid;
    logic [31:0] IF_instr;
    logic [31:0] IF_pc_plus_4;

    always #5 clk = ~clk;

    fetch_prefetch_stage #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk             (clk),
        .startin         (startin),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .id_ready        (id_ready),
        .if_valid        (if_valid),
        .IF_instr        (IF_instr),
        .IF_pc_plus_4    (IF_pc_plus_4)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference: the instructions ID should currently be able to see, in
    // program order. Requests are tagged with an epoch; a redirect or reset
    // starts a new epoch and responses from older epochs are stale.
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pcp4;
    } entry_t;

    entry_t      q[$];
    int          epoch = 0;
    logic        mem_pending = 1'b0;
    int          mem_wait = 0;
    logic [31:0] mem_addr = 32'h0;
    int          mem_epoch = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    logic [31:0] exp_fetch = RESET_PC;
    bit          inject_junk = 1'b0;
    int          stale_acks = 0;
    int          pops = 0;

    logic        s_req;
    logic [31:0] s_addr;
    logic        s_valid;
    logic [31:0] s_instr;
    logic [31:0] s_pcp4;

    // Memory contents: a scrambled function of the address, never zero at 0
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Runs one clock cycle with the given ID/redirect inputs, plays the
    // memory, checks all outputs against the reference and advances it.
    task automatic applyStimulus(input logic rdy, input logic redir, input logic [31:0] tgt);
        logic exp_req;
        logic acked;
        id_ready        = rdy;
        redirect_valid  = redir;
        redirect_target = tgt;
        imem_ack        = mem_pending && (mem_wait == 0);
        imem_rdata      = imem_ack ? mem_word(mem_addr) : 32'hDEAD_BEEF;
        if (inject_junk && !mem_pending) begin
            imem_ack   = 1'b1;
            imem_rdata = 32'hBAD0_BAD0;
        end
        inject_junk = 1'b0;

        @(negedge clk);
        s_req   = imem_req;
        s_addr  = imem_addr;
        s_valid = if_valid;
        s_instr = IF_instr;
        s_pcp4  = IF_pc_plus_4;

        exp_req = !mem_pending && !redir && (q.size() < DEPTH);
        checkOutput("imem_req", {31'b0, s_req}, {31'b0, exp_req});
        if (s_req) checkOutput("imem_addr", s_addr, exp_fetch);
        if (q.size() > 0) begin
            checkOutput("if_valid", {31'b0, s_valid}, 32'd1);
            checkOutput("IF_instr", s_instr, q[0].instr);
            checkOutput("IF_pc_plus_4", s_pcp4, q[0].pcp4);
        end else begin
            checkOutput("if_valid", {31'b0, s_valid}, 32'd0);
            checkOutput("IF_instr", s_instr, 32'h0);
            checkOutput("IF_pc_plus_4", s_pcp4, 32'h0);
        end

        @(posedge clk);
        #1;
        acked = imem_ack && mem_pending;
        if (acked) begin
            mem_pending = 1'b0;
            if (mem_epoch != epoch || redir) stale_acks++;
        end
        if (redir) begin
            q.delete();
            epoch++;
            exp_fetch = {tgt[31:2], 2'b00};
        end else begin
            if (rdy && q.size() > 0) begin
                void'(q.pop_front());
                pops++;
            end
            if (acked && mem_epoch == epoch) begin
                q.push_back('{instr: mem_word(mem_addr), pcp4: mem_addr + 32'd4});
            end
        end
        if (s_req) begin
            mem_pending = 1'b1;
            mem_addr    = s_addr;
            mem_epoch   = epoch;
            mem_wait    = int'($urandom_range(lat_max, lat_min)) - 1;
            exp_fetch   = exp_fetch + 32'd4;
        end else if (mem_pending && mem_wait > 0) begin
            mem_wait--;
        end
    endtask

    // Asserts reset asynchronously, checks outputs clear at once, holds it
    // for a few edges and releases it just after a rising edge.
    task automatic doReset(input int cycles);
        startin = 1'b0;
        #1;
        checkOutput("rst_imem_req", {31'b0, imem_req}, 32'd0);
        checkOutput("rst_if_valid", {31'b0, if_valid}, 32'd0);
        checkOutput("rst_IF_instr", IF_instr, 32'h0);
        checkOutput("rst_IF_pc_plus_4", IF_pc_plus_4, 32'h0);
        repeat (cycles) @(posedge clk);
        #1;
        startin     = 1'b1;
        q.delete();
        epoch++;
        mem_pending = 1'b0;
        exp_fetch   = RESET_PC;
    endtask

    typedef struct {
        logic        rdy;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pcp4;
    } vec_t;

    vec_t tbl[8];

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int          nreq;
        logic        late_req;
        logic        found;
        logic        saw_100;
        logic [31:0] first_addr;
        int          stale_base;
        int          rdy_pct;

        // Back-to-back fetch from reset with single-cycle memory
        tbl[0] = '{1'b1, 1'b1, 32'h0, 1'b0, 32'h0};
        tbl[1] = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h0};
        tbl[2] = '{1'b1, 1'b1, 32'h4, 1'b1, 32'h4};
        tbl[3] = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h0};
        tbl[4] = '{1'b1, 1'b1, 32'h8, 1'b1, 32'h8};
        tbl[5] = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h0};
        tbl[6] = '{1'b1, 1'b1, 32'hC, 1'b1, 32'hC};
        tbl[7] = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h0};

        lat_min = 1;
        lat_max = 1;
        doReset(2);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(tbl[i].rdy, 1'b0, 32'h0);
            checkOutput("t1_req", {31'b0, s_req}, {31'b0, tbl[i].exp_req});
            if (tbl[i].exp_req) checkOutput("t1_addr", s_addr, tbl[i].exp_addr);
            checkOutput("t1_valid", {31'b0, s_valid}, {31'b0, tbl[i].exp_valid});
            checkOutput("t1_pcp4", s_pcp4, tbl[i].exp_pcp4);
            if (tbl[i].exp_valid) checkOutput("t1_instr", s_instr, mem_word(tbl[i].exp_pcp4 - 32'd4));
        end

        // ID stall: exactly DEPTH fetches, then drain back-to-back
        doReset(2);
        nreq     = 0;
        late_req = 1'b0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0);
            if (s_req) nreq++;
            if (i >= 10) late_req = late_req | s_req;
        end
        checkOutput("t2_fetch_count", nreq, DEPTH);
        checkOutput("t2_req_quiet", {31'b0, late_req}, 32'd0);
        found      = 1'b0;
        first_addr = 32'hFFFF_FFFF;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, 32'h0);
            checkOutput("t2_drain_valid", {31'b0, s_valid}, 32'd1);
            checkOutput("t2_drain_pcp4", s_pcp4, 32'd4 * (i + 1));
            if (s_req && !found) begin
                found      = 1'b1;
                first_addr = s_addr;
            end
        end
        checkOutput("t2_resume_seen", {31'b0, found}, 32'd1);
        checkOutput("t2_resume_addr", first_addr, 32'h10);

        // Redirect while a 3-cycle request is in flight
        lat_min = 3;
        lat_max = 3;
        doReset(2);
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("t3_first_req", {31'b0, s_req}, 32'd1);
        stale_base = stale_acks;
        applyStimulus(1'b1, 1'b1, 32'h43);
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            applyStimulus(1'b1, 1'b0, 32'h0);
            if (s_req) found = 1'b1;
            else checkOutput("t3_valid_low", {31'b0, s_valid}, 32'd0);
        end
        checkOutput("t3_reissue_seen", {31'b0, found}, 32'd1);
        checkOutput("t3_target_addr", s_addr, 32'h40);
        checkOutput("t3_stale_acks", stale_acks - stale_base, 32'd1);

        // Redirect in the same cycle as the ack
        lat_min = 2;
        lat_max = 2;
        doReset(2);
        applyStimulus(1'b1, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h0);
        stale_base = stale_acks;
        applyStimulus(1'b1, 1'b1, 32'h80);
        checkOutput("t4_dropped_ack", stale_acks - stale_base, 32'd1);
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("t4_next_req", {31'b0, s_req}, 32'd1);
        checkOutput("t4_next_addr", s_addr, 32'h80);
        checkOutput("t4_valid_low", {31'b0, s_valid}, 32'd0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 32'h0);

        // Two redirects on consecutive cycles while discarding
        lat_min = 4;
        lat_max = 4;
        doReset(2);
        applyStimulus(1'b1, 1'b0, 32'h0);
        stale_base = stale_acks;
        applyStimulus(1'b1, 1'b1, 32'h100);
        applyStimulus(1'b1, 1'b1, 32'h200);
        found   = 1'b0;
        saw_100 = 1'b0;
        for (int i = 0; i < 15 && !found; i++) begin
            applyStimulus(1'b1, 1'b0, 32'h0);
            if (s_req) begin
                found = 1'b1;
                if (s_addr == 32'h100) saw_100 = 1'b1;
            end
        end
        checkOutput("t5_reissue_seen", {31'b0, found}, 32'd1);
        checkOutput("t5_target_addr", s_addr, 32'h200);
        checkOutput("t5_no_old_target", {31'b0, saw_100}, 32'd0);
        checkOutput("t5_stale_acks", stale_acks - stale_base, 32'd1);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            applyStimulus(1'b1, 1'b0, 32'h0);
            if (s_valid) found = 1'b1;
        end
        checkOutput("t5_first_valid", {31'b0, found}, 32'd1);
        checkOutput("t5_first_pcp4", s_pcp4, 32'h204);

        // Reset mid-burst with the FIFO half full, then a late ack
        lat_min = 1;
        lat_max = 1;
        doReset(2);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("t6_half_full", q.size(), 32'd2);
        doReset(2);
        inject_junk = 1'b1;
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("t6_first_req", {31'b0, s_req}, 32'd1);
        checkOutput("t6_first_addr", s_addr, RESET_PC);
        found = 1'b0;
        for (int i = 0; i < 6 && !found; i++) begin
            applyStimulus(1'b1, 1'b0, 32'h0);
            if (s_valid) found = 1'b1;
        end
        checkOutput("t6_first_valid", {31'b0, found}, 32'd1);
        checkOutput("t6_first_pcp4", s_pcp4, RESET_PC + 32'd4);
        checkOutput("t6_first_instr", s_instr, mem_word(RESET_PC));

        // Randomized traffic: variable latency, stalls, redirects, resets
        lat_min = 1;
        lat_max = 4;
        doReset(2);
        pops    = 0;
        rdy_pct = 90;
        for (int i = 0; i < 2000; i++) begin
            if (i % 200 == 0) begin
                case ($urandom_range(2, 0))
                    0:       rdy_pct = 15;
                    1:       rdy_pct = 60;
                    default: rdy_pct = 95;
                endcase
            end
            if ($urandom_range(399, 0) == 0) begin
                doReset(1 + int'($urandom_range(1, 0)));
            end else begin
                applyStimulus($urandom_range(99, 0) < rdy_pct,
                              $urandom_range(24, 0) == 0,
                              $urandom);
            end
        end
        checkOutput("rand_progress", {31'b0, pops > 100}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
